// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the completer, the master and the bench.
//   apb_slv_state_e : completer FSM state encoding (IDLE / ACCESS).
//   apb_xfer_t      : one APB transfer as issued by a master (addr, write, wdata).
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 16;

  typedef enum logic {
    APB_IDLE,
    APB_ACCESS
  } apb_slv_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_xfer_t;

endpackage

// File: rtl/apb_slave_ram.sv
// -----------------------------------------------------------------------------
// apb_slave_ram
// MEM_DEPTH x DATA_WIDTH register-file storage for apb_slave_mem.
// Synchronous write, combinational read. Contents are not reset.
// Ports:
//   clk    in  : clock, rising edge
//   we     in  : write enable
//   waddr  in  : write word address
//   wdata  in  : write data
//   raddr  in  : read word address
//   rdata  out : mem[raddr], or 0 when raddr is outside the array
// -----------------------------------------------------------------------------
module apb_slave_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 200
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic w_ok;
  logic r_ok;

  // Local range guards keep array indexing in bounds regardless of caller.
  assign w_ok = ({1'b0, waddr} < DEPTH_LIM);
  assign r_ok = ({1'b0, raddr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = r_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB3 completer backed by a MEM_DEPTH-word register file, with WAIT_STATES
// pready-low cycles per access phase and an error response for addresses
// at or above MEM_DEPTH.
// Ports:
//   pclk      in  : bus clock, rising edge
//   preset    in  : synchronous active-high reset
//   psel      in  : completer select
//   penable   in  : access phase indicator
//   pwrite    in  : 1 = write, 0 = read
//   paddr     in  : word address
//   pwdata    in  : write data
//   pready    out : transfer completes this cycle
//   pslverr   out : error response, only while pready=1
//   prdata    out : read data, held from setup capture until IDLE re-entered
//   state_dbg out : current FSM state, for observation only
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE; the completer then holds pready=0 for WAIT_STATES cycles of the access
// phase and raises pready for exactly one cycle, on whose closing edge the
// transfer is done. Dropping psel during the access phase abandons the transfer
// without side effects. Address, direction and write data are taken only from
// the setup cycle.
// -----------------------------------------------------------------------------
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_DEPTH   = 200,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output apb_slv_state_e        state_dbg
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_INIT  = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

  apb_slv_state_e state;
  apb_slv_state_e state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic                  capture;
  logic                  count_down;
  logic                  leave;
  logic                  mem_we;
  logic                  setup_err;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Unsigned compare at full address width plus one bit of headroom.
  assign setup_err = ({1'b0, paddr} >= DEPTH_LIM);

  apb_slave_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (pclk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (paddr),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= APB_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    count_down = 1'b0;
    leave      = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      APB_IDLE: begin
        // penable without a preceding setup is not a transfer.
        if (psel && !penable) begin
          capture = 1'b1;
          state_d = APB_ACCESS;
        end
      end
      APB_ACCESS: begin
        if (!psel) begin
          leave   = 1'b1;
          state_d = APB_IDLE;
        end else if (cnt != '0) begin
          count_down = 1'b1;
        end else begin
          leave   = 1'b1;
          state_d = APB_IDLE;
          // Reset on the completion edge wins over the write.
          mem_we  = wr_q && !err_q && !preset;
        end
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase
  end

  // Captured transfer, wait counter and held read data.
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (capture) begin
        addr_q   <= paddr;
        wr_q     <= pwrite;
        wdata_q  <= pwdata;
        cnt      <= CNT_INIT;
        err_q    <= setup_err;
        prdata_q <= (!pwrite && !setup_err) ? ram_rdata : '0;
      end else if (count_down) begin
        cnt <= cnt - CNT_W'(1);
      end else if (leave) begin
        cnt      <= '0;
        err_q    <= 1'b0;
        prdata_q <= '0;
      end
    end
  end

  // Registered-only decode: no input reaches pready or pslverr.
  assign pready    = (state == APB_ACCESS) && (cnt == '0);
  assign pslverr   = pready && err_q;
  assign prdata    = prdata_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
// Directed bench for apb_slave_mem. The driver issues APB transfers and pushes
// the expected {pslverr, prdata} and completion cycle into queues; a monitor
// pops and compares whenever pready is seen. A second instance built with
// WAIT_STATES=0 is checked directly for the two-cycle transfer.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WS = 2;
  localparam int W  = DW + 1;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- DUT (default build) ----------------
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;
  apb_slv_state_e state_dbg;

  apb_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (200),
    .WAIT_STATES(WS)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prdata   (prdata),
    .state_dbg(state_dbg)
  );

  // ---------------- DUT (zero wait states) ----------------
  logic          z_psel = 1'b0;
  logic          z_penable = 1'b0;
  logic          z_pwrite = 1'b0;
  logic [AW-1:0] z_paddr = '0;
  logic [DW-1:0] z_pwdata = '0;
  logic          z_pready;
  logic          z_pslverr;
  logic [DW-1:0] z_prdata;
  apb_slv_state_e z_state_dbg;

  apb_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (200),
    .WAIT_STATES(0)
  ) dut_ws0 (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (z_psel),
    .penable  (z_penable),
    .pwrite   (z_pwrite),
    .paddr    (z_paddr),
    .pwdata   (z_pwdata),
    .pready   (z_pready),
    .pslverr  (z_pslverr),
    .prdata   (z_prdata),
    .state_dbg(z_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic apb_xfer_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    apb_xfer_t x;
    x.addr  = a;
    x.write = w;
    x.wdata = d;
    return x;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (mon_en) begin
      if (pready !== 1'b1) begin
        checks++;
        if (pslverr !== 1'b0) begin
          errors++;
          $display("FAIL pslverr_without_pready got=%b exp=0 (cycle %0d)", pslverr, cyc);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if ({pslverr, prdata} !== e) begin
          errors++;
          $display("FAIL response got={err=%b,data=%h} exp={err=%b,data=%h} (cycle %0d)",
                   pslverr, prdata, e[W-1], e[DW-1:0], cyc);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL completion_cycle got=%0d exp=%0d", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  // Full transfer; returns at mid-cycle of the completion cycle so a following
  // call places its setup in the very next cycle.
  task automatic apb_xfer(input apb_xfer_t x, input logic exp_err, input logic [DW-1:0] exp_data);
    int n;
    @(posedge pclk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = x.addr;
    pwrite  = x.write;
    pwdata  = x.wdata;
    exp_q.push_back({exp_err, exp_data});
    exp_cyc_q.push_back(cyc + 1 + WS);
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    if (pready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%h got=no_pready exp=pready", x.addr);
    end
  endtask

  // Setup, then kill the transfer in the first wait cycle by dropping psel
  // or by asserting reset.
  task automatic apb_abort(input apb_xfer_t x, input bit by_reset);
    @(posedge pclk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = x.addr;
    pwrite  = x.write;
    pwdata  = x.wdata;
    @(posedge pclk); #1;
    if (by_reset) begin
      preset  = 1'b1;
      penable = 1'b1;
    end else begin
      psel    = 1'b0;
      penable = 1'b0;
    end
    @(negedge pclk);
    chk("abort_wait_pready", pready, 0);
    @(posedge pclk); #1;
    preset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort_state_idle", state_dbg, APB_IDLE);
    chk("abort_prdata", prdata, 0);
    repeat (3) begin
      @(posedge pclk); #1;
      @(negedge pclk);
      chk("abort_no_pready", pready, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;

    // Reset held for two edges.
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_pready", pready, 0);
    chk("reset_pslverr", pslverr, 0);
    chk("reset_prdata", prdata, 16'h0000);
    chk("reset_state", state_dbg, APB_IDLE);
    @(posedge pclk); #1;
    preset = 1'b0;
    mon_en = 1'b1;

    // penable with no setup: no response, and no write to 8'h10.
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h10;
    pwdata  = 16'hDEAD;
    repeat (3) begin
      @(negedge pclk);
      chk("orphan_penable_pready", pready, 0);
      @(posedge pclk); #1;
    end
    penable = 1'b0;
    pwrite  = 1'b0;

    // Write then read.
    apb_xfer(mk(8'h10, 1'b1, 16'hA5C3), 1'b0, 16'h0000);
    idle(1);
    apb_xfer(mk(8'h10, 1'b0, 16'h0000), 1'b0, 16'hA5C3);
    idle(1);
    @(negedge pclk);
    chk("prdata_cleared_in_idle", prdata, 0);

    // Back-to-back, no idle cycles.
    apb_xfer(mk(8'h00, 1'b1, 16'h1111), 1'b0, 16'h0000);
    apb_xfer(mk(8'h01, 1'b1, 16'h2222), 1'b0, 16'h0000);
    apb_xfer(mk(8'hC7, 1'b1, 16'h7E57), 1'b0, 16'h0000);
    apb_xfer(mk(8'hC7, 1'b0, 16'h0000), 1'b0, 16'h7E57);
    apb_xfer(mk(8'h00, 1'b0, 16'h0000), 1'b0, 16'h1111);
    apb_xfer(mk(8'h01, 1'b0, 16'h0000), 1'b0, 16'h2222);
    idle(2);

    // Out of range: first illegal word and the top of the address space.
    apb_xfer(mk(8'hC8, 1'b1, 16'hFFFF), 1'b1, 16'h0000);
    apb_xfer(mk(8'hC8, 1'b0, 16'h0000), 1'b1, 16'h0000);
    apb_xfer(mk(8'hFF, 1'b0, 16'h0000), 1'b1, 16'h0000);
    apb_xfer(mk(8'hC7, 1'b0, 16'h0000), 1'b0, 16'h7E57);
    idle(1);

    // Abort by dropping psel, then by reset.
    apb_xfer(mk(8'h20, 1'b1, 16'h0BAD), 1'b0, 16'h0000);
    idle(1);
    apb_abort(mk(8'h20, 1'b1, 16'h1234), 1'b0);
    apb_xfer(mk(8'h20, 1'b0, 16'h0000), 1'b0, 16'h0BAD);
    idle(1);
    apb_abort(mk(8'h20, 1'b1, 16'h1234), 1'b1);
    apb_xfer(mk(8'h20, 1'b0, 16'h0000), 1'b0, 16'h0BAD);
    apb_xfer(mk(8'h10, 1'b0, 16'h0000), 1'b0, 16'hA5C3);
    idle(2);

    // Zero-wait-state build: pready in the cycle directly after setup.
    @(posedge pclk); #1;
    z_psel = 1'b1; z_penable = 1'b0; z_pwrite = 1'b1; z_paddr = 8'h03; z_pwdata = 16'h5A5A;
    @(negedge pclk);
    chk("ws0_setup_pready", z_pready, 0);
    @(posedge pclk); #1;
    z_penable = 1'b1;
    @(negedge pclk);
    chk("ws0_write_pready", z_pready, 1);
    chk("ws0_write_pslverr", z_pslverr, 0);
    @(posedge pclk); #1;
    z_penable = 1'b0; z_pwrite = 1'b0;
    @(posedge pclk); #1;
    z_penable = 1'b1;
    @(negedge pclk);
    chk("ws0_read_pready", z_pready, 1);
    chk("ws0_read_pslverr", z_pslverr, 0);
    chk("ws0_read_prdata", z_prdata, 16'h5A5A);
    @(posedge pclk); #1;
    z_penable = 1'b0; z_paddr = 8'hC8;
    @(posedge pclk); #1;
    z_penable = 1'b1;
    @(negedge pclk);
    chk("ws0_err_pready", z_pready, 1);
    chk("ws0_err_pslverr", z_pslverr, 1);
    chk("ws0_err_prdata", z_prdata, 0);
    @(posedge pclk); #1;
    z_psel = 1'b0; z_penable = 1'b0;
    @(negedge pclk);
    chk("ws0_idle_pready", z_pready, 0);

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer with an internal DEPTH x DATA_WIDTH register-file memory, a fixed parameterised number of wait states and an out-of-range error response. It sits directly downstream of the APB master on the same bus and consumes its psel/penable/pwrite/paddr/pwdata phases. It returns pready/pslverr/prdata, which the master's read path and error handling consume.

## Interface
- ADDR_WIDTH, 8: paddr width.
- DATA_WIDTH, 16: pwdata/prdata width.
- MEM_DEPTH, 200: number of implemented words. Legal range is 1..2**ADDR_WIDTH. Addresses >= MEM_DEPTH are errors.
- WAIT_STATES, 2: pready-low cycles inserted in every access phase. Legal range is 0..15.
- pclk  in  1  bus clock; all logic is on the rising edge.
- preset  in  1  reset; synchronous, active-high (already decided).
- psel  in  1  completer select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  word address.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer completes in this cycle.
- pslverr  out  1  error flag, valid only while pready=1.
- prdata  out  DATA_WIDTH  read data, valid only while pready=1 on a successful read.

## Operation
- FSM with two states, IDLE and ACCESS.
- **IDLE:**
  - On psel=1 and penable=0 (setup phase), capture the following, then go to ACCESS:
    - addr_q <= paddr; wr_q <= pwrite; wdata_q <= pwdata; cnt <= WAIT_STATES; err_q <= (paddr >= MEM_DEPTH).
    - prdata <= (read and in range) ? mem[paddr] : 0.
  - penable=1 without a preceding setup is ignored: stay in IDLE, pready stays 0.
- **ACCESS:**
  - If psel=0, abort: go to IDLE, no write, outputs return to 0.
  - Else if cnt != 0: cnt <= cnt-1, pready=0.
  - Else (cnt == 0): this is the completion cycle, with pready=1 and pslverr=err_q.
    - On the closing edge, if wr_q=1 and err_q=0: mem[addr_q] <= wdata_q.
    - Next state is IDLE.
    - If psel=1 and penable=0 in the cycle after completion, the new setup is captured normally, so back-to-back transfers are supported.
- **Errors:**
  - Error writes leave memory untouched.
  - Error reads return prdata=0.
  - pslverr=0 whenever pready=0.
- **Outputs:**
  - pready and pslverr are decoded from flops only; there is no combinational path from any input.
  - prdata is held from capture until IDLE is re-entered, then cleared to 0.
- **Width rules:**
  - cnt width is max(1, $clog2(WAIT_STATES+1)); cnt never wraps.
  - The address comparison is unsigned, at full ADDR_WIDTH.
- Memory contents are not reset. A read before any write returns unspecified data.

## Timing
- **Reset values:** state=IDLE, pready=0, pslverr=0, prdata=0, cnt=0.
- Reset asserted mid-ACCESS aborts the transfer with no memory write, and takes effect at the next edge.
- With setup in cycle T, pready=1 in cycle T+1+WAIT_STATES.
- WAIT_STATES=0 gives a two-cycle APB transfer.
- Write data is visible to a read whose setup is in the cycle after the write's completion cycle, so read-after-write needs no bypass.
- Master-side assumption: paddr, pwrite and pwdata are stable through ACCESS. The completer uses only the values captured at setup.

## Structure
- Shared package apb_pkg holds:
  - typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;
  - the APB transfer struct (addr, write, wdata), reused by the master and by the bench.
- One sub-module, apb_slave_ram: MEM_DEPTH x DATA_WIDTH array with synchronous write and combinational read, instantiated once.
- The FSM, counter and response logic stay in apb_slave_mem.

## Test plan
All scenarios use the defaults (ADDR_WIDTH=8, DATA_WIDTH=16, MEM_DEPTH=200, WAIT_STATES=2).
- **Reset:** assert preset for 2 cycles -> pready=0, pslverr=0, prdata=16'h0000. Drive penable=1 with psel=0 -> no response.
- **Write/read:** write 16'hA5C3 to address 8'h10, then read 8'h10 -> the read's pready rises exactly 3 cycles after its setup, pslverr=0, prdata=16'hA5C3.
- **Back-to-back:** writes to 8'h00, 8'h01 and 8'hC7, then read 8'hC7 with no idle cycles between them -> each completes in 3 cycles and the read returns the value just written.
- **Out of range:** write 16'hFFFF to 8'hC8, then read 8'hC8 -> pslverr=1 with pready=1, and prdata=0. A read of 8'hC7 then shows its old value unchanged.
- **Abort:** write 16'h1234 to 8'h20 and drop psel in the first wait cycle -> no pready, and a later read of 8'h20 returns its prior value. Repeat with preset asserted mid-ACCESS -> same result.
- **Zero wait states (WAIT_STATES=0 build):** any read -> pready=1 in the cycle directly after setup.
